// File: rtl/otp_verify_fsm.sv
// One-time-password verify controller: captures the OTP and the user digit on button
// rises, compares them, counts attempts and holds each status for the display stage.
module otp_verify_fsm #(
  parameter int DIGIT_W      = 4,
  parameter int MAX_ATTEMPTS = 3,
  parameter int HOLD_CYCLES  = 500000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] otp_digit,
  input  logic               otp_latch,
  input  logic [DIGIT_W-1:0] user_in,
  input  logic               user_latch,
  output logic [DIGIT_W-1:0] otp_q,
  output logic [DIGIT_W-1:0] user_q,
  output logic               otp_valid,
  output logic               user_valid,
  output logic [1:0]         attempt_no,
  output logic [1:0]         status,
  output logic               hold_active,
  output logic [2:0]         state_dbg
);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_WAIT_USER   = 3'd1;
  localparam logic [2:0] ST_COMPARE     = 3'd2;
  localparam logic [2:0] ST_SHOW_UNLOCK = 3'd3;
  localparam logic [2:0] ST_SHOW_ERROR  = 3'd4;
  localparam logic [2:0] ST_LOCKED      = 3'd5;

  localparam logic [1:0] STS_NONE   = 2'b00;
  localparam logic [1:0] STS_UNLOCK = 2'b01;
  localparam logic [1:0] STS_ERROR  = 2'b10;
  localparam logic [1:0] STS_LOCKED = 2'b11;

  localparam int             CNT_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]     MAX_A   = 2'(MAX_ATTEMPTS);

  logic [2:0]         state_q, state_d;
  logic               otp_s_q, otp_p_q, usr_s_q, usr_p_q;
  logic [DIGIT_W-1:0] otp_cap_q, otp_cap_d, usr_cap_q, usr_cap_d;
  logic               otp_vld_q, otp_vld_d, usr_vld_q, usr_vld_d;
  logic [1:0]         att_q, att_d, sts_q, sts_d;
  logic               hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               otp_rise, usr_rise;
  logic [1:0]         att_inc;

  // Levels are sampled once, then compared against the previous sample; only a 0->1 acts.
  assign otp_rise = otp_s_q & ~otp_p_q;
  assign usr_rise = usr_s_q & ~usr_p_q;
  assign att_inc  = att_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    otp_cap_d = otp_cap_q;
    usr_cap_d = usr_cap_q;
    otp_vld_d = otp_vld_q;
    usr_vld_d = usr_vld_q;
    att_d     = att_q;
    sts_d     = sts_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (otp_rise) begin
          otp_cap_d = otp_digit;
          otp_vld_d = 1'b1;
          att_d     = 2'd0;
          state_d   = ST_WAIT_USER;
        end
      end
      ST_WAIT_USER: begin
        // A fresh OTP overrides a submission arriving on the same cycle.
        if (otp_rise) begin
          otp_cap_d = otp_digit;
          att_d     = 2'd0;
        end else if (usr_rise) begin
          usr_cap_d = user_in;
          usr_vld_d = 1'b1;
          state_d   = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        att_d  = att_inc;
        cnt_d  = HOLD_M1;
        hold_d = 1'b1;
        if (otp_cap_q == usr_cap_q) begin
          sts_d   = STS_UNLOCK;
          state_d = ST_SHOW_UNLOCK;
        end else if (att_inc == MAX_A) begin
          sts_d   = STS_LOCKED;
          state_d = ST_LOCKED;
        end else begin
          sts_d   = STS_ERROR;
          state_d = ST_SHOW_ERROR;
        end
      end
      ST_SHOW_UNLOCK, ST_LOCKED: begin
        if (cnt_q == '0) begin
          hold_d    = 1'b0;
          sts_d     = STS_NONE;
          otp_vld_d = 1'b0;
          usr_vld_d = 1'b0;
          att_d     = 2'd0;
          otp_cap_d = '0;
          usr_cap_d = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SHOW_ERROR: begin
        if (cnt_q == '0) begin
          hold_d    = 1'b0;
          sts_d     = STS_NONE;
          usr_vld_d = 1'b0;
          state_d   = ST_WAIT_USER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      otp_s_q   <= 1'b0;
      otp_p_q   <= 1'b0;
      usr_s_q   <= 1'b0;
      usr_p_q   <= 1'b0;
      otp_cap_q <= '0;
      usr_cap_q <= '0;
      otp_vld_q <= 1'b0;
      usr_vld_q <= 1'b0;
      att_q     <= 2'd0;
      sts_q     <= STS_NONE;
      hold_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      otp_s_q   <= otp_latch;
      otp_p_q   <= otp_s_q;
      usr_s_q   <= user_latch;
      usr_p_q   <= usr_s_q;
      otp_cap_q <= otp_cap_d;
      usr_cap_q <= usr_cap_d;
      otp_vld_q <= otp_vld_d;
      usr_vld_q <= usr_vld_d;
      att_q     <= att_d;
      sts_q     <= sts_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
    end
  end

  assign otp_q       = otp_cap_q;
  assign user_q      = usr_cap_q;
  assign otp_valid   = otp_vld_q;
  assign user_valid  = usr_vld_q;
  assign attempt_no  = att_q;
  assign status      = sts_q;
  assign hold_active = hold_q;
  assign state_dbg   = state_q;

endmodule
